// File: rtl/dot_matrix_scan_ctrl_if.sv
// Frame handshake between the pattern producer (master) and the scan controller (slave).
`timescale 1ns/1ps
interface dot_matrix_scan_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic [ROWS*COLS-1:0] frame_data;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (output frame_data, output frame_valid, input  frame_ready);
  modport slave  (input  frame_data, input  frame_valid, output frame_ready);
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan controller for an LED dot matrix with a double-buffered frame.
// Optional feature macro: BRIGHTNESS_EN adds the bright port and on-time PWM per slot.
`timescale 1ns/1ps
module dot_matrix_scan_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 10_000,
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dot_matrix_scan_ctrl_if.slave   fb,
`ifdef BRIGHTNESS_EN
  input  logic [2:0]              bright,
`endif
  output logic [ROWS-1:0]         row_sel,
  output logic [COLS-1:0]         col_out,
  output logic                    frame_done
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int SW  = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                     state;
  logic [SW-1:0]              slot_cnt;
  logic [RW-1:0]              row_idx;
  logic [ROWS-1:0][COLS-1:0]  active, pending;
  logic                       pending_valid;
  logic                       tick, last_row, accept, col_on;
  logic [31:0]                on_end;

  assign tick      = (32'(slot_cnt) == 32'(DIV - 1));
  assign last_row  = (32'(row_idx)  == 32'(ROWS - 1));
  assign accept    = fb.frame_valid && !pending_valid;
  assign fb.frame_ready = !pending_valid;

`ifdef BRIGHTNESS_EN
  // Brightness is latched at slot start so the on-window never shifts mid-slot.
  logic [2:0] bright_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               bright_q <= 3'd0;
    else if (state == SCAN && slot_cnt == '0) bright_q <= bright;
  end
  assign on_end = 32'(BLANK_CYCLES)
                + ((32'(bright_q) + 32'd1) * 32'(DIV - BLANK_CYCLES)) / 32'd8;
`else
  assign on_end = 32'(DIV);
`endif

  assign col_on = (32'(slot_cnt) >= 32'(BLANK_CYCLES)) && (32'(slot_cnt) < on_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      slot_cnt      <= '0;
      row_idx       <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      row_sel       <= '0;
      col_out       <= '0;
      frame_done    <= 1'b0;
    end else begin
      // Accept and swap are mutually exclusive on pending_valid, so ordering is safe.
      if (accept) begin
        pending       <= fb.frame_data;
        pending_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          slot_cnt   <= '0;
          row_idx    <= '0;
          row_sel    <= '0;
          col_out    <= '0;
          frame_done <= 1'b0;
          if (pending_valid) begin
            active        <= pending;
            pending_valid <= 1'b0;
            state         <= SCAN;
          end
        end
        SCAN: begin
          row_sel    <= {{(ROWS-1){1'b0}}, 1'b1} << row_idx;
          col_out    <= col_on ? active[row_idx] : '0;
          frame_done <= tick && last_row;
          slot_cnt   <= tick ? '0 : slot_cnt + 1'b1;
          if (tick) begin
            row_idx <= last_row ? '0 : row_idx + 1'b1;
            // Swap only at the frame boundary so a displayed frame is never torn.
            if (last_row && pending_valid) begin
              active        <= pending;
              pending_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
